adder32: RTL and testbench

ADDER32 -- requirements
Module: adder32

---
 rtl/adder32_pkg.sv | 51 +++++
 rtl/adder32_cla4.sv | 49 ++++
 rtl/adder32.sv | 64 ++++++
 tb/tb_adder32.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/adder32_pkg.sv
// ---------------------------------------------------------------------------
// adder32_pkg
// Shared constants, types and the second-level carry lookahead helper used by
// the registered 32-bit carry-lookahead adder.
//   ADDER_WIDTH : operand width (32)
//   CLA_BLOCK   : width of one carry-lookahead slice (4)
//   NUM_BLOCKS  : number of slices making up the operand width (8)
// ---------------------------------------------------------------------------
package adder32_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int CLA_BLOCK   = 4;
    localparam int NUM_BLOCKS  = ADDER_WIDTH / CLA_BLOCK;

    typedef logic [ADDER_WIDTH-1:0] word_t;
    typedef logic [NUM_BLOCKS-1:0]  group_t;
    typedef logic [NUM_BLOCKS:0]    carry_t;

    // Second-level lookahead: every slice carry-in is formed directly from the
    // group generate/propagate terms and the adder carry-in, so no carry has
    // to ripple through a lower slice before it is known.
    //   c[k] = G[k-1] | P[k-1]G[k-2] | ... | P[k-1]..P[0]cin
    function automatic carry_t lookahead_carries(
        input group_t g,
        input group_t p,
        input logic   cin
    );
        carry_t c;
        logic   term;
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int k = 1; k <= NUM_BLOCKS; k++) begin
            c[k] = 1'b0;
            for (int j = 0; j < k; j++) begin
                term = g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & p[m];
                end
                c[k] = c[k] | term;
            end
            term = cin;
            for (int m = 0; m < k; m++) begin
                term = term & p[m];
            end
            c[k] = c[k] | term;
        end
        return c;
    endfunction

endpackage

// File: rtl/adder32_cla4.sv
// ---------------------------------------------------------------------------
// cla4
// 4-bit carry-lookahead slice. All internal carries are written out in
// two-level form from the bit generate/propagate terms; the slice also
// reports its group generate/propagate for the second-level lookahead.
// Ports:
//   a, b  [3:0] in  : operand nibbles
//   cin         in  : carry into bit 0 of the slice
//   sum   [3:0] out : sum nibble
//   G           out : slice generates a carry on its own
//   P           out : slice passes cin through to its carry-out
// ---------------------------------------------------------------------------
module cla4
    import adder32_pkg::*;
(
    input  logic [CLA_BLOCK-1:0] a,
    input  logic [CLA_BLOCK-1:0] b,
    input  logic                 cin,
    output logic [CLA_BLOCK-1:0] sum,
    output logic                 G,
    output logic                 P
);

    logic [CLA_BLOCK-1:0] gen_s;
    logic [CLA_BLOCK-1:0] prop_s;
    logic [CLA_BLOCK-1:0] carry_s;

    // Bit generate/propagate, lookahead carries, sum and group terms.
    always_comb begin
        gen_s      = a & b;
        prop_s     = a ^ b;

        carry_s[0] = cin;
        carry_s[1] = gen_s[0] | (prop_s[0] & cin);
        carry_s[2] = gen_s[1] | (prop_s[1] & gen_s[0])
                   | (prop_s[1] & prop_s[0] & cin);
        carry_s[3] = gen_s[2] | (prop_s[2] & gen_s[1])
                   | (prop_s[2] & prop_s[1] & gen_s[0])
                   | (prop_s[2] & prop_s[1] & prop_s[0] & cin);

        sum        = prop_s ^ carry_s;

        G          = gen_s[3] | (prop_s[3] & gen_s[2])
                   | (prop_s[3] & prop_s[2] & gen_s[1])
                   | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]);
        P          = &prop_s;
    end

endmodule

// File: rtl/adder32.sv
// ---------------------------------------------------------------------------
// adder32
// Registered 32-bit unsigned adder, one-cycle latency, one add per clock.
// Eight cla4 slices are joined by a second-level carry lookahead; the 33-bit
// result is captured in an output register with synchronous active-low reset.
// Ports (positional order kept for existing instantiations):
//   s     [31:0] out : registered sum bits
//   co           out : registered carry-out (sum bit 32)
//   a     [31:0] in  : unsigned operand A
//   b     [31:0] in  : unsigned operand B
//   ci           in  : carry-in
//   clk          in  : clock, rising edge active
//   rst_n        in  : synchronous reset, active low
// ---------------------------------------------------------------------------
module adder32
    import adder32_pkg::*;
(
    output logic [ADDER_WIDTH-1:0] s,
    output logic                   co,
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    input  logic                   ci,
    input  logic                   clk,
    input  logic                   rst_n
);

    group_t g_s;
    group_t p_s;
    carry_t carry_s;
    word_t  sum_s;
    word_t  s_r;
    logic   co_r;

    // Slice carries come from the lookahead, never from a neighbouring slice.
    always_comb begin
        carry_s = lookahead_carries(g_s, p_s, ci);
    end

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_slice
        cla4 u_cla4 (
            .a   (a[i*CLA_BLOCK +: CLA_BLOCK]),
            .b   (b[i*CLA_BLOCK +: CLA_BLOCK]),
            .cin (carry_s[i]),
            .sum (sum_s[i*CLA_BLOCK +: CLA_BLOCK]),
            .G   (g_s[i]),
            .P   (p_s[i])
        );
    end

    // Output register; reset ignores the operands so unknown inputs cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_r  <= 32'h0000_0000;
            co_r <= 1'b0;
        end else begin
            s_r  <= sum_s;
            co_r <= carry_s[NUM_BLOCKS];
        end
    end

    assign s  = s_r;
    assign co = co_r;

endmodule

// File: tb/tb_adder32.sv
// ---------------------------------------------------------------------------
// tb_adder32
// Table of directed vectors, hand-written reset/throughput sequences and a
// random sweep. Every vector driven pushes its expected {co,s} onto a queue;
// the entry is popped and compared one clock later.
// ---------------------------------------------------------------------------
module tb_adder32;

    logic [31:0] s;
    logic        co;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        clk;
    logic        rst_n;

    adder32 dut (
        .s     (s),
        .co    (co),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        string       name;
    } vec_t;

    typedef struct {
        logic [32:0] sum;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_bad;
    logic [32:0] last_exp;
    logic        have_last;

    // Compare outputs against the oldest queued expectation.
    task automatic check_out();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({co, s} !== e.sum) begin
                n_bad++;
                $display("FAIL %s: got co=%0b s=%08h, want co=%0b s=%08h",
                         e.name, co, s, e.sum[32], e.sum[31:0]);
            end
            last_exp  = e.sum;
            have_last = 1'b1;
        end
    endtask

    // One clock: check previous result, apply new inputs, queue the expectation.
    task automatic drive(input logic [31:0] a_v, input logic [31:0] b_v,
                         input logic ci_v, input logic rst_v,
                         input logic [32:0] exp_v, input string name);
        exp_t e;
        @(negedge clk);
        check_out();
        a     = a_v;
        b     = b_v;
        ci    = ci_v;
        rst_n = rst_v;
        e.sum  = exp_v;
        e.name = name;
        exp_q.push_back(e);
        // Reset must not act before the edge: outputs still hold.
        if (!rst_v && have_last) begin
            #1;
            n_cmp++;
            if ({co, s} !== last_exp) begin
                n_bad++;
                $display("FAIL async_hold_%s: got co=%0b s=%08h, want co=%0b s=%08h",
                         name, co, s, last_exp[32], last_exp[31:0]);
            end
        end
    endtask

    function automatic logic [32:0] ref_sum(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {32'h0000_0000, c};
    endfunction

    vec_t vecs[10];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        n_cmp     = 0;
        n_bad     = 0;
        have_last = 1'b0;
        last_exp  = 33'h0;
        a         = 32'h0;
        b         = 32'h0;
        ci        = 1'b0;
        rst_n     = 1'b0;

        vecs[0] = '{32'd520,        32'd10,         1'b1, 32'd531,        1'b0, "520+10+1"};
        vecs[1] = '{32'd37,         32'd48,         1'b0, 32'd85,         1'b0, "37+48+0"};
        vecs[2] = '{32'd127,        32'd127,        1'b1, 32'd255,        1'b0, "127+127+1"};
        vecs[3] = '{32'hFFFF_FFFF,  32'h0000_0000,  1'b1, 32'h0000_0000,  1'b1, "full_chain"};
        vecs[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1, "all_ones"};
        vecs[5] = '{32'h0000_0000,  32'h0000_0000,  1'b0, 32'h0000_0000,  1'b0, "zero"};
        vecs[6] = '{32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0000_0000,  1'b1, "msb_wrap"};
        vecs[7] = '{32'h0000_FFFF,  32'h0000_0001,  1'b0, 32'h0001_0000,  1'b0, "half_carry"};
        vecs[8] = '{32'h0FFF_FFFF,  32'h0000_0000,  1'b1, 32'h1000_0000,  1'b0, "seven_slices"};
        vecs[9] = '{32'h7FFF_FFFF,  32'h0000_0001,  1'b0, 32'h8000_0000,  1'b0, "signed_ovf_no_flag"};

        // Reset state, with unknown operands held on the inputs.
        drive(32'hx, 32'hx, 1'bx, 1'b0, 33'h0, "reset_x_inputs");
        drive(32'd1, 32'd2, 1'b0, 1'b0, 33'h0, "reset_state");

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1,
                  {vecs[i].co, vecs[i].s}, vecs[i].name);
        end

        // Back-to-back throughput.
        drive(32'd125, 32'd110, 1'b1, 1'b1, 33'd236, "b2b_0");
        drive(32'd63,  32'd211, 1'b0, 1'b1, 33'd274, "b2b_1");
        drive(32'd100, 32'd200, 1'b0, 1'b1, 33'd300, "b2b_2");

        // Reset for one edge, then first cycle after release loads normally.
        drive(32'd245, 32'd2, 1'b0, 1'b0, 33'h0,   "rst_245_2");
        drive(32'd245, 32'd2, 1'b0, 1'b1, 33'd247, "post_rst_245_2");

        // Mid-stream reset discards the in-flight result.
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 33'h1_0000_0000, "pre_midrst");
        drive(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 33'h0, "midrst");
        drive(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 33'h30, "post_midrst");

        // Random sweep against the 33-bit reference.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(1, 0));
            drive(ra, rb, rc, 1'b1, ref_sum(ra, rb, rc), "random");
        end

        // Drain the last queued result.
        @(negedge clk);
        check_out();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
